// File: rtl/eager_fanout_fork.sv
// Stream fork broadcasting one ready/valid token to every enabled and selected branch.
// Eager mode lets branches take the token one at a time; lazy mode hands it to all at once.
module eager_fanout_fork #(
    parameter int NUM_OUT    = 6,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_OUT-1:0]            cfg_en,
    input  logic [NUM_OUT-1:0]            cfg_sel,
    input  logic                          cfg_eager,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [CNT_WIDTH-1:0]          tok_count
);

    logic [NUM_OUT-1:0]   active;
    logic [NUM_OUT-1:0]   sat;
    logic [NUM_OUT-1:0]   fire;
    logic [NUM_OUT-1:0]   done_p0;
    logic [CNT_WIDTH-1:0] cnt_p0;
    logic                 consume;

    assign active   = cfg_en & cfg_sel;
    assign out_data = {NUM_OUT{in_data}};

    // A stale done bit on an inactive branch is harmless: sat is already set by ~active.
    assign sat  = ~active | done_p0 | out_ready;
    assign fire = out_valid & out_ready;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = '0;
        if (cfg_eager) begin
            in_ready  = (&sat) & ~flush;
            out_valid = {NUM_OUT{in_valid & ~flush}} & active & ~done_p0;
        end else begin
            in_ready  = (&(~active | out_ready)) & ~flush;
            out_valid = {NUM_OUT{in_valid & in_ready}} & active;
        end
    end

    assign consume   = in_valid & in_ready;
    assign tok_count = cnt_p0;

    // Per-token served mask and consumed-token counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_p0 <= '0;
            cnt_p0  <= '0;
        end else if (flush) begin
            done_p0 <= '0;
            cnt_p0  <= '0;
        end else if (consume) begin
            done_p0 <= '0;
            cnt_p0  <= cnt_p0 + 1'b1;
        end else if (cfg_eager) begin
            done_p0 <= done_p0 | fire;
        end else begin
            done_p0 <= '0;
        end
    end

endmodule
